// File: rtl/spi_master_pkg.sv
`default_nettype none
// spi_master_pkg - shared types and register map for spi_master_wb_gen (rev 1.0)
package spi_master_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_CPOL     = 0;
  localparam int CTRL_CPHA     = 1;
  localparam int CTRL_CSHOLD   = 2;
  localparam int CTRL_LSBFIRST = 3;
  localparam int CTRL_CS_LSB   = 4;
  localparam int CTRL_CS_MSB   = 7;

endpackage
`default_nettype wire

// File: rtl/spi_sck_gen.sv
`default_nettype none
// spi_sck_gen - registered half-period tick every max(div,1) cycles while enabled (rev 1.0)
module spi_sck_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 CLK_I,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] cnt_next;
  logic [DIV_WIDTH-1:0] limit;

  assign limit    = (div == '0) ? ONE : div;
  assign cnt_next = cnt + ONE;

  // The tick is registered, so the first one after enable arrives one cycle late;
  // that extra cycle is the chip-select setup margin.
  always_ff @(posedge CLK_I) begin
    if (reset || !enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt_next == limit) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt_next;
      tick <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_wb_gen.sv
`default_nettype none
// spi_master_wb_gen - parametrised Wishbone SPI master, runtime mode/divider/CS hold (rev 1.0)
// Define SPI_LSB_FIRST_EN to let CTRL[3] select LSB-first frames.
module spi_master_wb_gen
  import spi_master_pkg::*;
#(
  parameter int NUM_CHIP_SELECTS = 3,
  parameter int DATA_WIDTH       = 8,
  parameter int DIV_WIDTH        = 8,
  parameter int DEFAULT_CLK_DIV  = 4
) (
  input  logic                        CLK_I,
  input  logic                        reset,
  input  logic [1:0]                  ADR_I,
  input  logic [DATA_WIDTH-1:0]       DAT_I,
  input  logic                        WE_I,
  input  logic                        STB_I,
  output logic                        ACK_O,
  output logic                        RTY_O,
  output logic [DATA_WIDTH-1:0]       DAT_O,
  input  logic                        miso,
  output logic                        mosi,
  output logic                        sck,
  output logic [NUM_CHIP_SELECTS-1:0] chipSelects
);

  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

  state_t state, state_next;
  logic [7:0]            ctrl, ctrl_pend, ctrl_new;
  logic [DIV_WIDTH-1:0]  div, div_pend, div_new;
  logic                  ctrl_pend_vld, div_pend_vld;
  logic [DATA_WIDTH-1:0] tx_sh, rx_sh, rx, rdata;
  logic [EW-1:0]         edge_cnt;
  logic [3:0]            cs_idx;
  logic                  rx_valid, cs_active, tick, lsb_first;
  logic                  busy, accept, data_wr, start, refuse, cfg_direct;
  logic                  ctrl_wr, div_wr, ctrl_apply, div_apply;
  logic                  cpol, cpha, leading, sample, shift_out, shifting;

`ifdef SPI_LSB_FIRST_EN
  localparam logic [7:0] CTRL_MASK = 8'hFF;
  assign lsb_first = ctrl[CTRL_LSBFIRST];
`else
  localparam logic [7:0] CTRL_MASK = 8'hF7;
  assign lsb_first = 1'b0;
`endif

  assign busy       = (state != IDLE);
  assign accept     = STB_I && !ACK_O && !RTY_O;
  assign data_wr    = accept && WE_I && (ADR_I == ADDR_DATA);
  assign start      = data_wr && !busy;
  assign refuse     = data_wr && busy;
  assign ctrl_wr    = accept && WE_I && (ADR_I == ADDR_CTRL);
  assign div_wr     = accept && WE_I && (ADR_I == ADDR_DIV);
  // Writes landing in DONE apply directly, as DONE always hands over to IDLE.
  assign cfg_direct = (state == IDLE) || (state == DONE);
  assign ctrl_apply = (ctrl_wr && cfg_direct) || ((state == DONE) && ctrl_pend_vld);
  assign ctrl_new   = (ctrl_wr && cfg_direct) ? (DAT_I[7:0] & CTRL_MASK) : ctrl_pend;
  assign div_apply  = (div_wr && cfg_direct) || ((state == DONE) && div_pend_vld);
  assign div_new    = (div_wr && cfg_direct) ? DIV_WIDTH'(DAT_I) : div_pend;

  assign cpol      = ctrl[CTRL_CPOL];
  assign cpha      = ctrl[CTRL_CPHA];
  assign shifting  = tick && (state == SHIFT);
  assign leading   = !edge_cnt[0];
  assign sample    = shifting && (leading ^ cpha);
  assign shift_out = shifting && (cpha ? (leading && (edge_cnt != '0)) : !leading);
  assign mosi      = lsb_first ? tx_sh[0] : tx_sh[DATA_WIDTH-1];

  spi_sck_gen #(.DIV_WIDTH(DIV_WIDTH)) u_sck_gen (
    .CLK_I  (CLK_I),
    .reset  (reset),
    .enable ((state == CS_SETUP) || (state == SHIFT)),
    .div    (div),
    .tick   (tick)
  );

  for (genvar i = 0; i < NUM_CHIP_SELECTS; i++) begin : g_cs
    assign chipSelects[i] = !(cs_active && (cs_idx == 4'(i)));
  end

  always_ff @(posedge CLK_I) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = CS_SETUP;
      CS_SETUP: if (tick) state_next = SHIFT;
      SHIFT:    if (tick && (edge_cnt == LAST_EDGE)) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (ADR_I)
      ADDR_DATA: rdata = rx;
      ADDR_CTRL: rdata = DATA_WIDTH'(ctrl);
      ADDR_DIV:  rdata = DATA_WIDTH'(div);
      default:   rdata = DATA_WIDTH'({rx_valid, busy});
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (reset) begin
      ACK_O         <= 1'b0;
      RTY_O         <= 1'b0;
      DAT_O         <= '0;
      sck           <= 1'b0;
      ctrl          <= '0;
      ctrl_pend     <= '0;
      ctrl_pend_vld <= 1'b0;
      div           <= DIV_WIDTH'(DEFAULT_CLK_DIV);
      div_pend      <= '0;
      div_pend_vld  <= 1'b0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      rx            <= '0;
      rx_valid      <= 1'b0;
      edge_cnt      <= '0;
      cs_active     <= 1'b0;
      cs_idx        <= '0;
    end else begin
      ACK_O <= accept && !refuse;
      RTY_O <= refuse;
      if (accept) DAT_O <= WE_I ? '0 : rdata;
      if (accept && !WE_I && (ADR_I == ADDR_DATA)) rx_valid <= 1'b0;

      if (start) begin
        tx_sh     <= DAT_I;
        edge_cnt  <= '0;
        cs_active <= 1'b1;
        cs_idx    <= ctrl[CTRL_CS_MSB:CTRL_CS_LSB];
      end

      if (state != SHIFT) sck <= cpol;
      else if (tick)      sck <= !sck;

      if (shifting) edge_cnt <= edge_cnt + EW'(1);
      if (shift_out) tx_sh <= lsb_first ? (tx_sh >> 1) : (tx_sh << 1);
      if (sample)
        rx_sh <= lsb_first ? {miso, rx_sh[DATA_WIDTH-1:1]} : {rx_sh[DATA_WIDTH-2:0], miso};

      if (state == DONE) begin
        rx        <= rx_sh;
        rx_valid  <= 1'b1;
        cs_active <= ctrl[CTRL_CSHOLD];
      end

      if (ctrl_wr && !cfg_direct) begin
        ctrl_pend     <= DAT_I[7:0] & CTRL_MASK;
        ctrl_pend_vld <= 1'b1;
      end else if (state == DONE) begin
        ctrl_pend_vld <= 1'b0;
      end
      if (div_wr && !cfg_direct) begin
        div_pend     <= DIV_WIDTH'(DAT_I);
        div_pend_vld <= 1'b1;
      end else if (state == DONE) begin
        div_pend_vld <= 1'b0;
      end

      // A held select is dropped once the new CTRL no longer asks for that same select.
      if (ctrl_apply) begin
        ctrl <= ctrl_new;
        if (!ctrl_new[CTRL_CSHOLD] || (ctrl_new[CTRL_CS_MSB:CTRL_CS_LSB] != cs_idx))
          cs_active <= 1'b0;
      end
      if (div_apply) div <= div_new;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_wb_gen.sv
`default_nettype none
// tb_spi_master_wb_gen - randomized self-checking bench with an SPI slave/monitor model
module tb_spi_master_wb_gen;

  localparam logic [1:0] A_DATA = 2'd0, A_CTRL = 2'd1, A_DIV = 2'd2, A_STATUS = 2'd3;

  logic       CLK_I = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] ADR_I = 2'd0;
  logic [7:0] DAT_I = 8'd0;
  logic       WE_I  = 1'b0;
  logic       STB_I = 1'b0;
  logic       ACK_O, RTY_O, mosi, sck;
  logic [7:0] DAT_O;
  logic [2:0] chipSelects;
  logic       miso = 1'b0;

  int checks = 0;
  int errors = 0;
  int held   = -1;
  int divs [5] = '{0, 1, 2, 3, 5};

  // monitor configuration (written by the main thread)
  int         m_gen = 0;
  bit         m_active = 1'b0;
  bit         m_cpha = 1'b0;
  int         m_div_eff = 1;
  logic [7:0] m_word = 8'd0;
  logic [2:0] m_exp_cs = 3'b111;
  // monitor results (written by the monitor only)
  int         mon_gen = 0;
  int         m_edges = 0;
  int         m_gap = 0;
  logic [7:0] m_mosi = 8'd0;
  bit         m_bad_hp = 1'b0, m_bad_mosi = 1'b0, m_bad_cs = 1'b0;
  logic       m_prev_sck = 1'b0, m_prev_mosi = 1'b0;

  spi_master_wb_gen #(
    .NUM_CHIP_SELECTS(3), .DATA_WIDTH(8), .DIV_WIDTH(8), .DEFAULT_CLK_DIV(4)
  ) dut (
    .CLK_I(CLK_I), .reset(reset), .ADR_I(ADR_I), .DAT_I(DAT_I), .WE_I(WE_I),
    .STB_I(STB_I), .ACK_O(ACK_O), .RTY_O(RTY_O), .DAT_O(DAT_O), .miso(miso),
    .mosi(mosi), .sck(sck), .chipSelects(chipSelects)
  );

  initial forever #5 CLK_I = ~CLK_I;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Slave model: presents the frame bit by bit and records what it samples on mosi.
  always @(negedge CLK_I) begin
    if (m_gen != mon_gen) begin
      mon_gen = m_gen;
      m_edges = 0; m_gap = 0; m_mosi = 8'd0;
      m_bad_hp = 1'b0; m_bad_mosi = 1'b0; m_bad_cs = 1'b0;
      m_prev_sck = sck; m_prev_mosi = mosi;
      miso = m_word[7];
    end else if (m_active) begin
      int bi;
      m_gap++;
      if (sck !== m_prev_sck) begin
        bit samp_edge;
        samp_edge = ((m_edges % 2) == 0) == (m_cpha == 1'b0);
        if (m_edges > 0 && m_gap != m_div_eff) m_bad_hp = 1'b1;
        if (chipSelects !== m_exp_cs) m_bad_cs = 1'b1;
        if (samp_edge) begin
          m_mosi = {m_mosi[6:0], mosi};
          if (mosi !== m_prev_mosi) m_bad_mosi = 1'b1;
        end
        m_edges++;
        m_gap = 0;
        m_prev_sck = sck;
        bi = m_cpha ? ((m_edges == 0) ? 0 : (m_edges - 1) / 2) : m_edges / 2;
        miso = (bi < 8) ? m_word[7 - bi] : 1'b0;
      end else if (m_edges > 0 && mosi !== m_prev_mosi) begin
        m_bad_mosi = 1'b1;
      end
      m_prev_mosi = mosi;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_cs(input int idx);
    logic [2:0] v;
    v = 3'b111;
    if (idx >= 0 && idx < 3) v[idx] = 1'b0;
    return v;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, output bit ack, output bit rty);
    @(negedge CLK_I);
    ADR_I = a; DAT_I = d; WE_I = 1'b1; STB_I = 1'b1;
    ack = 1'b0; rty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK_I);
      if (ACK_O || RTY_O) begin
        ack = ACK_O; rty = RTY_O;
        break;
      end
    end
    STB_I = 1'b0; WE_I = 1'b0;
    check("bus_resp_wr", 32'(ack | rty), 32'd1);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bit got;
    @(negedge CLK_I);
    ADR_I = a; WE_I = 1'b0; STB_I = 1'b1;
    got = 1'b0; d = 8'hxx;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK_I);
      if (ACK_O) begin
        got = 1'b1; d = DAT_O;
        break;
      end
    end
    STB_I = 1'b0;
    check("bus_resp_rd", 32'(got), 32'd1);
  endtask

  task automatic arm_monitor(input bit cpha, input int div, input int idx, input logic [7:0] word);
    m_cpha = cpha;
    m_div_eff = (div == 0) ? 1 : div;
    m_exp_cs = exp_cs(idx);
    m_word = word;
    m_active = 1'b1;
    m_gen++;
  endtask

  task automatic wait_idle();
    logic [7:0] d;
    d = 8'h01;
    for (int i = 0; i < 500; i++) begin
      bus_read(A_STATUS, d);
      if (!d[0]) break;
    end
    check("status_done", 32'(d[1:0]), 32'd2);
  endtask

  task automatic run_frame(input bit cpol, input bit cpha, input bit cshold, input int idx,
                           input int div, input logic [7:0] tx, input logic [7:0] word);
    bit a, r;
    logic [7:0] d, ctrl_v;
    logic [3:0] iv;
    iv = 4'(idx);
    ctrl_v = {iv, 1'b0, cshold, cpha, cpol};
    bus_write(A_CTRL, ctrl_v, a, r);
    if (held >= 0 && (!cshold || idx != held)) held = -1;
    check("cs_after_ctrl", 32'(chipSelects), 32'(exp_cs(held)));
    bus_write(A_DIV, 8'(div), a, r);
    bus_read(A_CTRL, d);
    check("ctrl_rd", 32'(d), 32'(ctrl_v));
    check("sck_idle", 32'(sck), 32'(cpol));
    arm_monitor(cpha, div, idx, word);
    bus_write(A_DATA, tx, a, r);
    check("data_ack", 32'({a, r}), 32'd2);
    bus_read(A_STATUS, d);
    check("status_busy", 32'(d[0]), 32'd1);
    bus_write(A_DATA, ~tx, a, r);
    check("busy_rty", 32'({a, r}), 32'd1);
    wait_idle();
    m_active = 1'b0;
    bus_read(A_DATA, d);
    check("rx_data", 32'(d), 32'(word));
    bus_read(A_STATUS, d);
    check("rx_valid_clr", 32'(d[1:0]), 32'd0);
    check("sck_edges", 32'(m_edges), 32'd16);
    check("half_period", 32'(m_bad_hp), 32'd0);
    check("mosi_word", 32'(m_mosi), 32'(tx));
    check("mosi_timing", 32'(m_bad_mosi), 32'd0);
    check("cs_during", 32'(m_bad_cs), 32'd0);
    held = cshold ? idx : -1;
    check("cs_after_frame", 32'(chipSelects), 32'(exp_cs(held)));
    check("sck_rest", 32'(sck), 32'(cpol));
  endtask

  initial begin
    bit a, r;
    logic [7:0] d;
    repeat (3) @(negedge CLK_I);
    reset = 1'b0;
    @(negedge CLK_I);
    check("rst_ack", 32'(ACK_O), 32'd0);
    check("rst_rty", 32'(RTY_O), 32'd0);
    check("rst_dat", 32'(DAT_O), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_cs", 32'(chipSelects), 32'd7);
    bus_read(A_CTRL, d);   check("rst_ctrl", 32'(d), 32'd0);
    bus_read(A_DIV, d);    check("rst_div", 32'(d), 32'd4);
    bus_read(A_STATUS, d); check("rst_status", 32'(d), 32'd0);

    run_frame(1'b0, 1'b0, 1'b0, 0, 1, 8'hA5, 8'h3C);
    run_frame(1'b1, 1'b1, 1'b0, 1, 3, 8'h81, 8'($urandom));

    run_frame(1'b0, 1'b0, 1'b1, 2, 1, 8'($urandom), 8'($urandom));
    run_frame(1'b0, 1'b0, 1'b1, 2, 2, 8'($urandom), 8'($urandom));
    bus_write(A_CTRL, 8'h20, a, r);
    held = -1;
    check("cs_release", 32'(chipSelects), 32'd7);

    run_frame(1'b0, 1'b1, 1'b0, 15, 0, 8'($urandom), 8'($urandom));

    // DIV written mid-transfer only takes effect once the frame is over
    bus_write(A_CTRL, 8'h00, a, r);
    bus_write(A_DIV, 8'd3, a, r);
    bus_write(A_DATA, 8'h5A, a, r);
    bus_write(A_DIV, 8'd7, a, r);
    check("div_pend_ack", 32'({a, r}), 32'd2);
    bus_read(A_DIV, d);
    check("div_rd_busy", 32'(d), 32'd3);
    wait_idle();
    bus_read(A_DIV, d);
    check("div_rd_applied", 32'(d), 32'd7);
    bus_read(A_DATA, d);

    // reset in the middle of SHIFT
    bus_write(A_CTRL, 8'h10, a, r);
    bus_write(A_DIV, 8'd2, a, r);
    arm_monitor(1'b0, 2, 1, 8'hC3);
    bus_write(A_DATA, 8'hE7, a, r);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK_I);
      if (m_edges >= 8) break;
    end
    check("reached_bit4", 32'(m_edges >= 8), 32'd1);
    reset = 1'b1;
    @(negedge CLK_I);
    check("midrst_cs", 32'(chipSelects), 32'd7);
    check("midrst_sck", 32'(sck), 32'd0);
    check("midrst_mosi", 32'(mosi), 32'd0);
    reset = 1'b0;
    m_active = 1'b0;
    held = -1;
    bus_read(A_STATUS, d); check("midrst_status", 32'(d), 32'd0);
    bus_read(A_CTRL, d);   check("midrst_ctrl", 32'(d), 32'd0);
    bus_read(A_DIV, d);    check("midrst_div", 32'(d), 32'd4);
    run_frame(1'b0, 1'b0, 1'b0, 1, 2, 8'($urandom), 8'($urandom));

    for (int n = 0; n < 16; n++) begin
      int dv, ix;
      dv = divs[$urandom_range(0, 4)];
      ix = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 15)) : int'($urandom_range(0, 2));
      run_frame(1'($urandom), 1'($urandom), 1'($urandom), ix, dv, 8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master_wb_gen.md
Name: spi_master_wb_gen

Overview:
- Parametrised Wishbone-slave SPI master, successor to the fixed 8-bit/mode-0 master.
- Configurable data width, chip-select count and runtime clock divider; runtime SPI mode (CPOL/CPHA); chip-select hold across transfers.
- Sits between the Wishbone bus and off-chip SPI peripherals; one transfer in flight at a time, with busy signalled via RTY_O.

Parameters:
- NUM_CHIP_SELECTS, 3, number of active-low chip selects (1..16).
- DATA_WIDTH, 8, SPI frame and bus data width (8..32).
- DIV_WIDTH, 8, width of the clock-divider register.
- DEFAULT_CLK_DIV, 4, reset value of DIV; SCK half-period = DIV CLK_I cycles.

Ports:
- CLK_I  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ADR_I  in  2  register select: 0 DATA, 1 CTRL, 2 DIV, 3 STATUS.
- DAT_I  in  DATA_WIDTH  write data.
- WE_I  in  1  write enable.
- STB_I  in  1  strobe.
- ACK_O  out  1  access accepted.
- RTY_O  out  1  DATA write refused while busy.
- DAT_O  out  DATA_WIDTH  read data, valid with ACK_O.
- miso  in  1  serial in.
- mosi  out  1  serial out.
- sck  out  1  SPI clock.
- chipSelects  out  NUM_CHIP_SELECTS  active-low selects.

Behaviour:
- Reset (reset, synchronous, active-high; clock CLK_I):
  - ACK_O=0, RTY_O=0, DAT_O=0, mosi=0, sck=0, chipSelects all 1.
  - CTRL=0, DIV=DEFAULT_CLK_DIV, RX=0, busy=0, rx_valid=0, FSM=IDLE.
  - Reset mid-transfer aborts immediately with the same values.
- Bus handshake:
  - An access is accepted when STB_I & ~ACK_O & ~RTY_O.
  - The next cycle pulses ACK_O (or RTY_O) for exactly 1 cycle.
  - Back-to-back strobes are therefore accepted every 2 cycles.
- Writes:
  - A DATA write when busy=0 loads the shift register, sets busy and enters CS_SETUP. ACK_O is pulsed.
  - A DATA write when busy=1 is ignored and RTY_O is pulsed instead.
  - CTRL and DIV writes while busy are ACKed but take effect only in IDLE; a pending value is applied on return to IDLE.
- CTRL bits:
  - [0] CPOL, [1] CPHA, [2] CSHOLD, [3] LSBFIRST (feature-gated), [7:4] CS index.
- Reads:
  - DATA returns RX and clears rx_valid.
  - STATUS returns {..0, rx_valid, busy}.
  - CTRL and DIV read back their register values.
- Clock divider:
  - Half-period tick when the counter equals max(DIV,1); the counter restarts at 0 on each tick.
  - DIV=0 behaves as DIV=1.
- FSM:
  - IDLE: sck=CPOL. Exit on a DATA write.
  - CS_SETUP: selected CS low, mosi = first bit. Hold 1 tick, then go to SHIFT.
  - SHIFT: 2*DATA_WIDTH ticks, toggling sck each tick.
    - CPHA=0: sample miso on leading edges, shift on trailing edges.
    - CPHA=1: shift on leading edges, sample on trailing edges.
  - DONE (1 cycle): RX <= shifted-in word, rx_valid=1, busy=0, sck=CPOL.
    - If CSHOLD=0, CS goes high; otherwise CS stays low.
- Held chip select:
  - Released in IDLE on a CTRL write that clears CSHOLD or changes the CS index.
  - Never more than one CS low at a time.
- CS index >= NUM_CHIP_SELECTS: transfer still runs, no CS asserted.
- Bit order: MSB first unless LSBFIRST.
- Latency: DATA write ACK to rx_valid = 1 + DIV*(2*DATA_WIDTH+1) + 1 cycles.

Optional Feature:
- SPI_LSB_FIRST_EN defined: CTRL[3] selects LSB-first shifting for both mosi and miso.
- Undefined: CTRL[3] is not stored and reads 0; frames are always MSB-first.

Decomposition:
- Package spi_master_pkg holds:
  - state enum {IDLE, CS_SETUP, SHIFT, DONE}.
  - register address constants ADDR_DATA/CTRL/DIV/STATUS.
  - CTRL bit-position constants.
- Sub-module spi_sck_gen: divider counter; inputs DIV and enable; output half-period tick.

Test Plan:
- Mode 0, DIV=1, CS idx 0: write DATA 0xA5 with miso fed 0x3C -> mosi shows 10100101 MSB-first on rising-edge samples; RX=0x3C; rx_valid=1; CS0 low then high; 8 rising sck edges.
- Mode 3 (CPOL=1, CPHA=1), DIV=3: write 0x81 -> sck idles 1; each half-period is 3 CLK_I cycles; mosi changes on falling edges; RX matches miso.
- Busy write: write DATA mid-transfer -> RTY_O pulses once; the in-flight frame is unchanged; STATUS reads busy=1.
- CSHOLD=1, idx 2: two DATA writes -> CS2 stays low between frames; a CTRL write with CSHOLD=0 then raises CS2 within 1 cycle.
- Reset mid-SHIFT: assert reset at bit 4 -> next cycle all CS=1, sck=0, busy=0; a subsequent transfer completes normally.
- DIV=0 and CS idx 15 with NUM_CHIP_SELECTS=3: the transfer runs at the DIV=1 rate and all CS remain high.
